ahb_burst_master: RTL and testbench
===================================

// Module: ahb_burst_master
// PURPOSE
//  Parametrised AHB master with a command interface. Executes single and
//  incrementing-burst reads and writes, honours slave wait states and ERROR
//  responses, and splits bursts at the 1KB boundary.
//  Sits between a requester (DMA/test sequencer) and the AHB decoder/slave mux.
// PARAMETERS
//  ADDR_W   32       haddr / cmd_addr width
//  DATA_W   32       hwdata/hrdata width; 32 or 64
//  SEL_W    2        slave-select width
//  LEN_W    4        cmd_len width; beats = cmd_len+1 (max 2^LEN_W)
//  HPROT    4'b0011  constant driven on hprot during transfers
// PORTS
//  hclk        in   1       bus clock
//  hresetn     in   1       async active-low reset
//  cmd_valid   in   1       command request
//  cmd_ready   out  1       high only in IDLE; cmd accepted on valid&ready
//  cmd_wr      in   1       1=write 0=read
//  cmd_addr    in   ADDR_W  start address (aligned to cmd_size)
//  cmd_len     in   LEN_W   beats-1
//  cmd_size    in   3       hsize; clamped to log2(DATA_W/8)
//  cmd_sel     in   SEL_W   target slave
//  cmd_lock    in   1       drives hmastlock for the whole command
//  wr_data     in   DATA_W  next write beat; must be valid whenever wr_pop can fire
//  wr_pop      out  1       wr_data consumed this cycle
//  rd_data     out  DATA_W  read beat
//  rd_valid    out  1       1-cycle pulse per completed read beat
//  done        out  1       1-cycle pulse, command finished
//  err         out  1       1-cycle pulse with done when terminated by ERROR
//  sel         out  SEL_W   registered cmd_sel
//  haddr/hwrite/hsize/hburst/hprot/htrans/hmastlock  out  AHB address/control
//  hwdata      out  DATA_W  write data, data phase
//  hready      out  1       = hreadyout (combinational) to slave HREADY
//  hreadyout   in   1       slave ready
//  hresp       in   1       0=OKAY 1=ERROR
//  hrdata      in   DATA_W  read data
// BEHAVIOUR
//  Reset: all outputs 0 (htrans=IDLE); state IDLE. Assertion mid-command
//   immediately abandons it; no done/err is issued.
//  FSM: IDLE -> ADDR (first address phase) -> BURST (address+data overlap)
//   -> LAST (final data phase only) -> IDLE; from any phase: ERR -> IDLE.
//  All AHB outputs registered. Accept at T0; T1 haddr=cmd_addr, htrans=NONSEQ.
//  Address/control advance only when hreadyout=1; while 0, every output is held.
//  Subsequent beats: htrans=SEQ; haddr += 1<<hsize, mod 2^ADDR_W.
//  hburst: 1 beat SINGLE, 4 INCR4, 8 INCR8, 16 INCR16, else INCR. If the
//   burst crosses a 1KB boundary, hburst=INCR for the whole command and the
//   beat at haddr[9:0]==0 is NONSEQ.
//  Write: wr_pop pulses in the cycle a write address phase completes;
//   hwdata <= wr_data the next cycle and is held through wait states.
//  Read: rd_data<=hrdata, rd_valid pulses 1 cycle after a data phase completes.
//  done: 1 cycle after the last data phase completes; cmd_ready rises the same
//   cycle. Single write: accept T0, addr T1, data T2, done T3.
//  ERROR: hresp=1 with hreadyout=0 -> next cycle htrans=IDLE, remaining beats
//   dropped. Once hreadyout=1 -> done=err=1, then IDLE. No rd_valid for the errored beat.
//  htrans=IDLE whenever no address phase is pending. cmd_valid outside IDLE is ignored.
// TESTING
//  Single write 0x100, data 0xDEADBEEF, hreadyout=1 -> NONSEQ T1, hwdata T2, done T3.
//  INCR4 read 0x200 size=2 -> haddr 200/204/208/20C, NONSEQ,SEQ,SEQ,SEQ, hburst=011, 4 rd_valid.
//  INCR8 write, hreadyout low 2 cycles on beat 3 -> all outputs held, exactly 8 wr_pop.
//  cmd_len=3 from 0x3F8 size=2 -> hburst=INCR, beat at 0x400 NONSEQ.
//  hresp=1 on beat 2 of INCR4 -> next htrans=IDLE, done+err together, no more wr_pop.
//  hresetn low mid-INCR16 -> outputs 0 at once; next cmd runs normally.

Source files
------------

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: turns one command (single or INCR burst) into AHB
// address/data phases, with wait-state stalls, ERROR abort and 1KB splitting.
module ahb_burst_master #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned LEN_W  = 4,
    parameter logic [3:0]  HPROT  = 4'b0011
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [2:0]        cmd_size,
    input  logic [SEL_W-1:0]  cmd_sel,
    input  logic              cmd_lock,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              err,
    output logic [SEL_W-1:0]  sel,
    output logic [ADDR_W-1:0] haddr,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [3:0]        hprot,
    output logic [1:0]        htrans,
    output logic              hmastlock,
    output logic [DATA_W-1:0] hwdata,
    output logic              hready,
    input  logic              hreadyout,
    input  logic              hresp,
    input  logic [DATA_W-1:0] hrdata
);
    localparam int unsigned MAX_SIZE = $clog2(DATA_W / 8);
    localparam int unsigned OFF_W    = LEN_W + 12;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    localparam logic [2:0] HB_SINGLE = 3'b000;
    localparam logic [2:0] HB_INCR   = 3'b001;
    localparam logic [2:0] HB_INCR4  = 3'b011;
    localparam logic [2:0] HB_INCR8  = 3'b101;
    localparam logic [2:0] HB_INCR16 = 3'b111;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_LAST, S_ERR} state_e;

    state_e state_q, state_d;

    logic              cmd_ready_q, cmd_ready_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic              hwrite_q, hwrite_d;
    logic [2:0]        hsize_q, hsize_d;
    logic [2:0]        hburst_q, hburst_d;
    logic [3:0]        hprot_q, hprot_d;
    logic [1:0]        htrans_q, htrans_d;
    logic              hmastlock_q, hmastlock_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [LEN_W-1:0]  addr_left_q, addr_left_d;

    logic              accept_c;
    logic              in_addr_c;
    logic              in_data_c;
    logic              addr_done_c;
    logic              data_ok_c;
    logic              err_start_c;
    logic              wr_pop_c;
    logic [2:0]        size_c;
    logic [OFF_W-1:0]  bytes_c;
    logic [OFF_W-1:0]  end_c;
    logic              cross_c;
    logic [2:0]        burst_c;
    logic [ADDR_W-1:0] addr_nxt_c;

    assign accept_c    = cmd_valid & cmd_ready_q;
    assign in_addr_c   = (state_q == S_ADDR) || (state_q == S_BURST);
    assign in_data_c   = (state_q == S_BURST) || (state_q == S_LAST);
    assign addr_done_c = in_addr_c & hreadyout;
    assign data_ok_c   = in_data_c & hreadyout & ~hresp;
    assign err_start_c = in_data_c & ~hreadyout & hresp;
    assign wr_pop_c    = (htrans_q != HT_IDLE) & hwrite_q & hreadyout;
    assign addr_nxt_c  = haddr_q + (ADDR_W'(1) << hsize_q);

    // Command decode: clamped size, 1KB crossing test and burst encoding
    always_comb begin
        size_c  = (cmd_size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : cmd_size;
        bytes_c = (OFF_W'(cmd_len) + OFF_W'(1)) << size_c;
        end_c   = OFF_W'(cmd_addr[9:0]) + bytes_c;
        cross_c = end_c > OFF_W'(1024);
        burst_c = HB_INCR;
        if (cross_c)                     burst_c = HB_INCR;
        else if (32'(cmd_len) == 32'd0)  burst_c = HB_SINGLE;
        else if (32'(cmd_len) == 32'd3)  burst_c = HB_INCR4;
        else if (32'(cmd_len) == 32'd7)  burst_c = HB_INCR8;
        else if (32'(cmd_len) == 32'd15) burst_c = HB_INCR16;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept_c) state_d = S_ADDR;
            S_ADDR:  if (hreadyout) state_d = (addr_left_q != '0) ? S_BURST : S_LAST;
            S_BURST: begin
                if (err_start_c)    state_d = S_ERR;
                else if (hreadyout) state_d = (addr_left_q != '0) ? S_BURST : S_LAST;
            end
            S_LAST: begin
                if (err_start_c)    state_d = S_ERR;
                else if (hreadyout) state_d = S_IDLE;
            end
            S_ERR:   if (hreadyout) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values; everything holds unless a phase advances
    always_comb begin
        cmd_ready_d = (state_d == S_IDLE);
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hburst_d    = hburst_q;
        hprot_d     = hprot_q;
        htrans_d    = htrans_q;
        hmastlock_d = hmastlock_q;
        hwdata_d    = hwdata_q;
        sel_d       = sel_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        addr_left_d = addr_left_q;

        if (state_q == S_IDLE && accept_c) begin
            haddr_d     = cmd_addr;
            htrans_d    = HT_NONSEQ;
            hwrite_d    = cmd_wr;
            hsize_d     = size_c;
            hburst_d    = burst_c;
            hprot_d     = HPROT;
            hmastlock_d = cmd_lock;
            sel_d       = cmd_sel;
            addr_left_d = cmd_len;
        end

        if (err_start_c) begin
            htrans_d = HT_IDLE;
        end else if (addr_done_c) begin
            if (addr_left_q != '0) begin
                haddr_d     = addr_nxt_c;
                htrans_d    = (addr_nxt_c[9:0] == 10'd0) ? HT_NONSEQ : HT_SEQ;
                addr_left_d = addr_left_q - LEN_W'(1);
            end else begin
                htrans_d = HT_IDLE;
            end
        end

        if (wr_pop_c) hwdata_d = wr_data;

        if (data_ok_c && !hwrite_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = hrdata;
        end

        if ((state_q == S_LAST || state_q == S_ERR) && hreadyout) begin
            done_d      = 1'b1;
            err_d       = (state_q == S_ERR);
            htrans_d    = HT_IDLE;
            hmastlock_d = 1'b0;
            hprot_d     = 4'd0;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            cmd_ready_q <= 1'b0;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'd0;
            hburst_q    <= 3'd0;
            hprot_q     <= 4'd0;
            htrans_q    <= HT_IDLE;
            hmastlock_q <= 1'b0;
            hwdata_q    <= '0;
            sel_q       <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            addr_left_q <= '0;
        end else begin
            cmd_ready_q <= cmd_ready_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hburst_q    <= hburst_d;
            hprot_q     <= hprot_d;
            htrans_q    <= htrans_d;
            hmastlock_q <= hmastlock_d;
            hwdata_q    <= hwdata_d;
            sel_q       <= sel_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
            addr_left_q <= addr_left_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign haddr     = haddr_q;
    assign hwrite    = hwrite_q;
    assign hsize     = hsize_q;
    assign hburst    = hburst_q;
    assign hprot     = hprot_q;
    assign htrans    = htrans_q;
    assign hmastlock = hmastlock_q;
    assign hwdata    = hwdata_q;
    assign sel       = sel_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign err       = err_q;
    assign wr_pop    = wr_pop_c;
    assign hready    = hreadyout;

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master: bench plays the slave and the
// requester, with hand-computed cycle-by-cycle expectations.
module tb_ahb_burst_master;
    logic        hclk;
    logic        hresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_sel;
    logic        cmd_lock;
    logic [31:0] wr_data;
    logic        wr_pop;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic        err;
    logic [1:0]  sel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    int          n_checks = 0;
    int          n_errors = 0;
    int          pops     = 0;
    logic [31:0] wbase    = 32'h0;

    ahb_burst_master dut (
        .hclk(hclk), .hresetn(hresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
        .cmd_sel(cmd_sel), .cmd_lock(cmd_lock),
        .wr_data(wr_data), .wr_pop(wr_pop),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
        .sel(sel), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hprot(hprot), .htrans(htrans), .hmastlock(hmastlock),
        .hwdata(hwdata), .hready(hready), .hreadyout(hreadyout),
        .hresp(hresp), .hrdata(hrdata)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; requester presents the next write beat after the edge
    task automatic step();
        @(posedge hclk);
        #1;
        wr_data = wbase + 32'(pops);
    endtask

    // Slave response for the current cycle, then note any write-data pop
    task automatic cyc(input logic rdy, input logic resp, input logic [31:0] rdata);
        hreadyout = rdy;
        hresp     = resp;
        hrdata    = rdata;
        #1;
        if (wr_pop) pops++;
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic lock, input logic [1:0] s);
        int n;
        n = 0;
        hreadyout = 1'b1;
        hresp     = 1'b0;
        while (!cmd_ready && n < 20) begin
            step();
            n++;
        end
        check("cmd_ready_wait", 64'(cmd_ready), 64'(1'b1));
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_size  = size;
        cmd_lock  = lock;
        cmd_sel   = s;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        hresetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = 32'h0;
        cmd_len   = 4'h0;
        cmd_size  = 3'h0;
        cmd_sel   = 2'h0;
        cmd_lock  = 1'b0;
        wr_data   = 32'h0;
        hreadyout = 1'b1;
        hresp     = 1'b0;
        hrdata    = 32'h0;

        // Reset state
        step();
        check("rst_htrans", 64'(htrans), 64'(2'b00));
        check("rst_haddr", 64'(haddr), 64'(32'h0));
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1'b0));
        check("rst_done", 64'(done), 64'(1'b0));
        check("rst_hprot", 64'(hprot), 64'(4'h0));
        step();
        hresetn = 1'b1;
        step();
        check("post_rst_ready", 64'(cmd_ready), 64'(1'b1));

        // Single write 0x100
        pops = 0; wbase = 32'hDEADBEEF;
        issue(1'b1, 32'h100, 4'd0, 3'd2, 1'b0, 2'd1);
        cyc(1'b1, 1'b0, 32'h0);
        check("sw_haddr", 64'(haddr), 64'(32'h100));
        check("sw_htrans", 64'(htrans), 64'(2'b10));
        check("sw_hwrite", 64'(hwrite), 64'(1'b1));
        check("sw_hburst", 64'(hburst), 64'(3'b000));
        check("sw_hsize", 64'(hsize), 64'(3'd2));
        check("sw_hprot", 64'(hprot), 64'(4'b0011));
        check("sw_sel", 64'(sel), 64'(2'd1));
        check("sw_ready_busy", 64'(cmd_ready), 64'(1'b0));
        check("sw_wr_pop", 64'(wr_pop), 64'(1'b1));
        check("sw_hready", 64'(hready), 64'(1'b1));
        step(); cyc(1'b1, 1'b0, 32'h0);
        check("sw_hwdata", 64'(hwdata), 64'(32'hDEADBEEF));
        check("sw_htrans_idle", 64'(htrans), 64'(2'b00));
        check("sw_done_early", 64'(done), 64'(1'b0));
        step(); cyc(1'b1, 1'b0, 32'h0);
        check("sw_done", 64'(done), 64'(1'b1));
        check("sw_err", 64'(err), 64'(1'b0));
        check("sw_ready_back", 64'(cmd_ready), 64'(1'b1));
        step(); cyc(1'b1, 1'b0, 32'h0);
        check("sw_done_pulse", 64'(done), 64'(1'b0));

        // INCR4 read at 0x200
        issue(1'b0, 32'h200, 4'd3, 3'd2, 1'b0, 2'd0);
        for (int i = 1; i <= 6; i++) begin
            cyc(1'b1, 1'b0, 32'hC0DE0000 + 32'(i));
            if (i == 1) check("r4_hburst", 64'(hburst), 64'(3'b011));
            if (i <= 4) begin
                check("r4_haddr", 64'(haddr), 64'(32'h200 + 32'(4 * (i - 1))));
                check("r4_htrans", 64'(htrans), (i == 1) ? 64'(2'b10) : 64'(2'b11));
            end else begin
                check("r4_htrans_idle", 64'(htrans), 64'(2'b00));
            end
            check("r4_rd_valid", 64'(rd_valid), 64'(i >= 3));
            if (i >= 3) check("r4_rd_data", 64'(rd_data), 64'(32'hC0DE0000 + 32'(i - 1)));
            check("r4_done", 64'(done), 64'(i == 6));
            step();
        end

        // INCR8 write at 0x300, slave stalls two cycles on beat 3
        pops = 0; wbase = 32'h5000;
        issue(1'b1, 32'h300, 4'd7, 3'd2, 1'b0, 2'd0);
        for (int i = 1; i <= 12; i++) begin
            cyc(!(i == 3 || i == 4), 1'b0, 32'h0);
            if (i == 1) check("w8_hburst", 64'(hburst), 64'(3'b101));
            check("w8_wr_pop", 64'(wr_pop), 64'((i <= 2) || (i >= 5 && i <= 10)));
            if (i >= 3 && i <= 5) begin
                check("w8_hold_haddr", 64'(haddr), 64'(32'h308));
                check("w8_hold_htrans", 64'(htrans), 64'(2'b11));
                check("w8_hold_hwdata", 64'(hwdata), 64'(32'h5001));
            end
            if (i == 10) check("w8_last_addr", 64'(haddr), 64'(32'h31C));
            if (i == 11) check("w8_last_data", 64'(hwdata), 64'(32'h5007));
            check("w8_done", 64'(done), 64'(i == 12));
            step();
        end
        check("w8_pop_count", 64'(pops), 64'(8));

        // 4-beat read from 0x3F8 crosses 1KB: INCR, NONSEQ at 0x400
        issue(1'b0, 32'h3F8, 4'd3, 3'd2, 1'b0, 2'd0);
        for (int i = 1; i <= 6; i++) begin
            cyc(1'b1, 1'b0, 32'h0);
            if (i == 1) check("kb_hburst", 64'(hburst), 64'(3'b001));
            if (i <= 4) begin
                check("kb_haddr", 64'(haddr), 64'(32'h3F8 + 32'(4 * (i - 1))));
                check("kb_htrans", 64'(htrans), (i == 1 || i == 3) ? 64'(2'b10) : 64'(2'b11));
            end
            check("kb_done", 64'(done), 64'(i == 6));
            step();
        end

        // ERROR on beat 2 data phase of INCR4 write
        pops = 0; wbase = 32'h7000;
        issue(1'b1, 32'h500, 4'd3, 3'd2, 1'b0, 2'd0);
        for (int i = 1; i <= 5; i++) begin
            cyc(i != 3, (i == 3 || i == 4), 32'h0);
            check("er_wr_pop", 64'(wr_pop), 64'(i <= 2));
            if (i == 3) begin
                check("er_haddr", 64'(haddr), 64'(32'h508));
                check("er_hwdata", 64'(hwdata), 64'(32'h7001));
            end
            if (i >= 4) check("er_htrans_idle", 64'(htrans), 64'(2'b00));
            check("er_done", 64'(done), 64'(i == 5));
            check("er_err", 64'(err), 64'(i == 5));
            check("er_rd_valid", 64'(rd_valid), 64'(1'b0));
            step();
        end
        hresp = 1'b0;
        check("er_pop_count", 64'(pops), 64'(2));
        check("er_ready_back", 64'(cmd_ready), 64'(1'b1));

        // Reset asserted mid INCR16 read
        issue(1'b0, 32'h800, 4'd15, 3'd2, 1'b1, 2'd3);
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b1, 1'b0, 32'h0);
            if (i == 1) begin
                check("rs_hburst", 64'(hburst), 64'(3'b111));
                check("rs_hmastlock", 64'(hmastlock), 64'(1'b1));
            end
            if (i < 3) step();
        end
        #2;
        hresetn = 1'b0;
        #1;
        check("rs_htrans", 64'(htrans), 64'(2'b00));
        check("rs_haddr", 64'(haddr), 64'(32'h0));
        check("rs_hburst0", 64'(hburst), 64'(3'b000));
        check("rs_hmastlock0", 64'(hmastlock), 64'(1'b0));
        check("rs_sel", 64'(sel), 64'(2'd0));
        check("rs_cmd_ready", 64'(cmd_ready), 64'(1'b0));
        step();
        step();
        check("rs_no_done", 64'(done), 64'(1'b0));
        hresetn = 1'b1;

        // Single write after reset, oversize request clamped to word
        pops = 0; wbase = 32'h12345678;
        issue(1'b1, 32'h40, 4'd0, 3'd3, 1'b0, 2'd2);
        cyc(1'b1, 1'b0, 32'h0);
        check("pr_haddr", 64'(haddr), 64'(32'h40));
        check("pr_htrans", 64'(htrans), 64'(2'b10));
        check("pr_hsize_clamp", 64'(hsize), 64'(3'd2));
        check("pr_sel", 64'(sel), 64'(2'd2));
        step(); cyc(1'b1, 1'b0, 32'h0);
        check("pr_hwdata", 64'(hwdata), 64'(32'h12345678));
        step(); cyc(1'b1, 1'b0, 32'h0);
        check("pr_done", 64'(done), 64'(1'b1));
        check("pr_err", 64'(err), 64'(1'b0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
